// File: rtl/axis_demapper_pkg.sv
// Shared definitions for the OFDM symbol demapper.
// Holds the demodulation mode encoding, the frame-tracking FSM states, the number of
// bits each mode contributes per symbol, and a helper that maps a mode to that count.
package axis_demapper_pkg;

    typedef enum logic [1:0] {
        DemodBpsk    = 2'd0,
        DemodQpsk    = 2'd1,
        DemodQam16   = 2'd2,
        DemodInvalid = 2'd3
    } demod_e;

    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } frame_state_e;

    localparam int unsigned BitsBpsk      = 1;
    localparam int unsigned BitsQpsk      = 2;
    localparam int unsigned BitsQam16     = 4;
    localparam int unsigned MaxBitsPerSym = 4;

    // Bits produced per symbol; an invalid mode produces none.
    function automatic logic [2:0] bits_per_mode(input demod_e mode);
        logic [2:0] n;
        case (mode)
            DemodBpsk:  n = 3'(BitsBpsk);
            DemodQpsk:  n = 3'(BitsQpsk);
            DemodQam16: n = 3'(BitsQam16);
            default:    n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/axis_demapper_slicer.sv
// Combinational hard-decision slicer for one I/Q symbol.
// Ports:
//   mode_i  - demodulation mode for this symbol
//   i_i/q_i - signed two's-complement I and Q components
//   thr_i   - unsigned QAM16 magnitude threshold
//   bits_o  - symbol bits, b0 at bit 0; bits beyond the mode's width are zero
module axis_demapper_slicer
    import axis_demapper_pkg::*;
#(
    parameter int unsigned DATA_W = 24
) (
    input  demod_e                   mode_i,
    input  logic [DATA_W-1:0]        i_i,
    input  logic [DATA_W-1:0]        q_i,
    input  logic [DATA_W-2:0]        thr_i,
    output logic [MaxBitsPerSym-1:0] bits_o
);

    // One extra bit so the magnitude of the most negative input is representable.
    logic [DATA_W:0] i_ext, q_ext, i_abs, q_abs, thr_ext;
    logic            i_pos, q_pos, i_inner, q_inner;

    always_comb begin
        i_ext   = {i_i[DATA_W-1], i_i};
        q_ext   = {q_i[DATA_W-1], q_i};
        i_abs   = i_ext[DATA_W] ? -i_ext : i_ext;
        q_abs   = q_ext[DATA_W] ? -q_ext : q_ext;
        thr_ext = {2'b00, thr_i};
        i_pos   = ~i_i[DATA_W-1];
        q_pos   = ~q_i[DATA_W-1];
        // Strict compare: a magnitude equal to the threshold counts as outer.
        i_inner = (i_abs < thr_ext);
        q_inner = (q_abs < thr_ext);

        bits_o = '0;
        case (mode_i)
            DemodBpsk:  bits_o = {3'b000, i_pos};
            DemodQpsk:  bits_o = {2'b00, q_pos, i_pos};
            DemodQam16: bits_o = {q_inner, q_pos, i_inner, i_pos};
            default:    bits_o = '0;
        endcase
    end

endmodule

// File: rtl/axis_ofdm_demapper.sv
// AXI-Stream OFDM demapper: slices I/Q symbols into hard bits and packs them LSB-first
// into OUT_W-bit output words. Mode and QAM16 threshold are latched per frame.
// Ports:
//   aclk, areset            - clock, synchronous active-high reset
//   s_axis_*                - input symbols {Q, I}, tlast marks last symbol of frame
//   m_axis_*                - packed output words, tlast on the word closing a frame
//   demod_type, qam16_thr   - sampled on the first beat of each frame
//   frame_err               - sticky: set by any frame that latched the invalid mode
module axis_ofdm_demapper
    import axis_demapper_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned OUT_W  = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    output logic                  s_axis_tready,
    input  logic [2*DATA_W-1:0]   s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [OUT_W-1:0]      m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic [1:0]            demod_type,
    input  logic [DATA_W-2:0]     qam16_thr,
    output logic                  frame_err
);

    localparam int unsigned CntW = $clog2(OUT_W + 1);

    frame_state_e          state_q, state_d;
    demod_e                mode_q, mode_d;
    logic [DATA_W-2:0]     thr_q, thr_d;
    logic [OUT_W-1:0]      acc_q, acc_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [OUT_W-1:0]      out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  err_q, err_d;

    logic                  beat;
    demod_e                mode_eff;
    logic [DATA_W-2:0]     thr_eff;
    logic [MaxBitsPerSym-1:0] sym_bits;
    logic [2:0]            sym_nbits;
    logic [OUT_W-1:0]      acc_next;
    logic [CntW-1:0]       cnt_next;

    // The first beat of a frame uses the live mode inputs; later beats use the latched copy.
    assign mode_eff = (state_q == StIdle) ? demod_e'(demod_type) : mode_q;
    assign thr_eff  = (state_q == StIdle) ? qam16_thr : thr_q;

    axis_demapper_slicer #(
        .DATA_W (DATA_W)
    ) u_slicer (
        .mode_i (mode_eff),
        .i_i    (s_axis_tdata[DATA_W-1:0]),
        .q_i    (s_axis_tdata[2*DATA_W-1:DATA_W]),
        .thr_i  (thr_eff),
        .bits_o (sym_bits)
    );

    assign sym_nbits     = bits_per_mode(mode_eff);
    assign s_axis_tready = !(out_valid_q && !m_axis_tready);
    assign beat          = s_axis_tvalid && s_axis_tready;
    // Symbol widths divide OUT_W, so a symbol never straddles two words.
    assign acc_next      = acc_q | (OUT_W'(sym_bits) << cnt_q);
    assign cnt_next      = cnt_q + CntW'(sym_nbits);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        thr_d       = thr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = err_q;

        if (out_valid_q && m_axis_tready) begin
            out_valid_d = 1'b0;
        end

        if (beat) begin
            if (state_q == StIdle) begin
                mode_d = mode_eff;
                thr_d  = thr_eff;
            end
            state_d = s_axis_tlast ? StIdle : StActive;

            if (mode_eff == DemodInvalid) begin
                err_d = 1'b1;
            end else if ((cnt_next == CntW'(OUT_W)) || s_axis_tlast) begin
                // Accumulator upper bits are already zero, which pads a short last word.
                out_data_d  = acc_next;
                out_valid_d = 1'b1;
                out_last_d  = s_axis_tlast;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_next;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= StIdle;
            mode_q      <= DemodBpsk;
            thr_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            thr_q       <= thr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign frame_err     = err_q;

endmodule

// File: doc/axis_ofdm_demapper.md
AXIS_OFDM_DEMAPPER -- requirements
Module: axis_ofdm_demapper

Interface
REQ-001 SHALL have parameter DATA_W, default 24, width of each signed I/Q component.
REQ-002 SHALL have parameter OUT_W, default 32, packed output word width; multiple of 4.
REQ-003 SHALL have ports aclk  in  1  sole clock; areset  in  1  reset. One clock; reset is synchronous and active-high.
REQ-004 SHALL have s_axis_tready out 1, s_axis_tdata in 2*DATA_W (I = [DATA_W-1:0], Q = [2*DATA_W-1:DATA_W], two's complement), s_axis_tvalid in 1, s_axis_tlast in 1 (last symbol of frame).
REQ-005 SHALL have m_axis_tready in 1, m_axis_tdata out OUT_W, m_axis_tvalid out 1, m_axis_tlast out 1.
REQ-006 SHALL have demod_type in 2 (0 BPSK, 1 QPSK, 2 QAM16, 3 invalid) and qam16_thr in DATA_W-1 (unsigned QAM16 slicing threshold).
REQ-007 SHALL have frame_err out 1, sticky flag for invalid-mode frames.

Function
REQ-008 SHALL sample demod_type and qam16_thr into frame registers on the first accepted beat of each frame (first beat after reset, or first beat after a tlast beat); changes mid-frame SHALL be ignored.
REQ-009 SHALL slice each symbol: BPSK 1 bit b0 = (I >= 0); QPSK 2 bits b0 = (I >= 0), b1 = (Q >= 0); QAM16 4 bits b0 = (I >= 0), b1 = (|I| < thr), b2 = (Q >= 0), b3 = (|Q| < thr).
REQ-010 SHALL compute |x| at DATA_W+1 bits so the most negative value does not overflow; |x| == thr SHALL give 0.
REQ-011 SHALL pack symbol bits LSB-first into an OUT_W accumulator, b0 of the earliest symbol at bit 0.
REQ-012 SHALL move the accumulator into a one-word output register when it holds OUT_W bits or the accepted beat has tlast; the register SHALL then be presented with m_axis_tvalid = 1 on the following cycle (latency 1 clock from completing beat).
REQ-013 SHALL zero-pad the unused upper bits of a partial word closed by tlast and set m_axis_tlast = 1 on that word only.
REQ-014 SHALL, when tlast coincides with an exactly full word, emit one word with tlast and no extra empty word.
REQ-015 SHALL hold m_axis_tdata/tvalid/tlast stable while m_axis_tvalid = 1 and m_axis_tready = 0.
REQ-016 SHALL drive s_axis_tready = !(m_axis_tvalid && !m_axis_tready); a beat SHALL be accepted only when s_axis_tvalid && s_axis_tready.
REQ-017 SHALL sustain one beat per clock when m_axis_tready stays 1.
REQ-018 SHALL, for a frame with latched mode 3, accept and discard all beats through tlast, emit no output, and set frame_err = 1 on the first beat.
REQ-019 SHALL keep frame_err set until reset.
REQ-020 SHALL track frame state with two states: IDLE (await first beat, latch mode) and ACTIVE (packing); a tlast beat SHALL return to IDLE, and an IDLE beat with tlast SHALL be a one-symbol frame.

Reset
REQ-021 SHALL, while areset = 1 at a rising aclk edge, clear m_axis_tvalid, m_axis_tlast, m_axis_tdata, frame_err, the accumulator and bit count, and enter IDLE.
REQ-022 SHALL discard any partial word or pending output on reset mid-frame; the next beat after reset starts a new frame.
REQ-023 SHALL drive s_axis_tready = 1 on the first cycle after reset release.

Structure
REQ-024 SHALL place mode encodings, bits-per-symbol constants and the bits-per-mode function in shared package axis_demapper_pkg.
REQ-025 SHALL implement symbol slicing (REQ-009/010) in one combinational sub-module axis_demapper_slicer; packing, handshake and frame FSM stay in the top.

Verification
REQ-026 SHALL cover BPSK: 32 beats with I alternating +5/-5, tlast on beat 32 -> one word 0x55555555 with tlast.
REQ-027 SHALL cover QPSK short frame: 3 beats (I,Q) = (+1,+1),(-1,+1),(+1,-1), tlast on beat 3 -> word 0x0000001B with tlast.
REQ-028 SHALL cover QAM16 with thr = 100: (I,Q) = (50,-200), tlast -> bits b0..b3 = 1,1,0,0, word 0x00000003 with tlast; also I = -2^23 slices b1 = 0.
REQ-029 SHALL cover backpressure: QPSK 32 beats, m_axis_tready = 0 for 10 cycles at word completion -> s_axis_tready = 0 during the stall, data stable, no beat lost, two words output.
REQ-030 SHALL cover mode switching: demod_type changed 0->1 mid-frame -> current frame stays BPSK; next frame uses QPSK; demod_type = 3 frame -> no output, frame_err = 1.
REQ-031 SHALL cover reset mid-frame: 10 BPSK beats, areset pulse, then 32 beats with tlast -> only one word, containing post-reset bits.
